svc_rv_wb: RTL and testbench
============================

# svc_rv_wb

Writeback sequencer that drives the write port of `svc_rv_regfile` (`rd_en`/`rd_addr`/`rd_data`) from two producers. The producers are the execute stage (ALU results, no back-pressure) and the load unit (late load data, valid/ready). It also holds a 32-entry pending-load scoreboard that decode queries on rs1/rs2 to stall on load-use hazards. It sits between EX/MEM and the register file in the svc RV core.

## Interface
Parameters:
- `XLEN`, 32, data width
- `STARVE_MAX`, 4, consecutive blocked cycles before the load hold raises `ex_stall` (only with `SVC_RV_WB_STARVE_EN`)

Ports:
- `clk` in 1: clock, single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `ex_valid` in 1: EX writeback request
- `ex_rd_addr` in 5: EX destination
- `ex_rd_data` in XLEN: EX result
- `ex_stall` out 1: upstream must hold `ex_valid`=0 while high
- `ld_issue` in 1: load issued; marks its destination busy
- `ld_issue_addr` in 5: issued load destination
- `ld_valid` in 1: load data valid
- `ld_ready` out 1: load data accepted when both `ld_valid` and `ld_ready` are high
- `ld_rd_addr` in 5: load destination
- `ld_data` in XLEN: load data
- `rs1_addr` in 5: decode query address, port 1
- `rs2_addr` in 5: decode query address, port 2
- `rs1_busy` out 1: rs1 has a pending load (combinational)
- `rs2_busy` out 1: rs2 has a pending load (combinational)
- `rd_en` out 1: regfile write enable, registered
- `rd_addr` out 5: regfile write address, registered
- `rd_data` out XLEN: regfile write data, registered

## Operation
- **EX request:** valid when `ex_valid` is high and `ex_rd_addr`≠0. Requests to x0 are discarded and never drive `rd_en`.
- **Load hold:** one-entry register (`hold_full`, addr, data).
  - A load handshake loads the hold.
  - `ld_ready` = ~`hold_full` | `drain`, so drain and refill can happen in the same cycle.
  - A load to x0 is accepted and then dropped: the hold stays empty and no scoreboard change occurs.
- **Selection each cycle:**
  - If `ex_stall` is high and `hold_full`: the hold is selected (`drain`=1).
  - Otherwise, if the EX request is valid: EX is selected.
  - Otherwise, if `hold_full`: the hold is selected (`drain`=1).
  - Otherwise: no write.
- **Output register:** the selected addr/data is registered into `rd_*` with `rd_en`=1. If nothing is selected, `rd_en`=0 and `rd_addr`/`rd_data` keep their previous values.
- **Scoreboard:** a 32-bit busy vector; bit 0 is always 0.
  - Set: `ld_issue` with `ld_issue_addr`≠0.
  - Clear: `drain` for the hold address.
  - Set and clear on the same address in the same cycle: set wins.
  - An EX write does not touch the scoreboard.
- **Busy outputs:** `rsN_busy` = busy[`rsN_addr`]. They reflect state before the current-cycle update; there is no bypass.
- **Starvation** (with `SVC_RV_WB_STARVE_EN`):
  - A counter increments each cycle that `hold_full` is high and `drain` is low.
  - The counter clears on `drain`.
  - `ex_stall` is registered: it rises the cycle after the counter reaches `STARVE_MAX` and falls the cycle after `drain`.
  - If `ex_valid` arrives while `ex_stall` is high, it is a protocol violation; the request is ignored.

## Timing
- **Reset values:** `rd_en`=0, `rd_addr`=0, `rd_data`=0, `ld_ready`=1, `ex_stall`=0, hold empty, scoreboard clear, starve counter 0.
- **EX latency:** request in cycle N → `rd_en` high in N+1, and the regfile commits at the edge that ends N+1.
- **Load latency:** handshake at the edge ending cycle N → hold full in N+1 → drained in N+1 if no EX request → `rd_en` high in N+2.
- **Busy clear:** the busy bit clears at the same edge that registers the drain, so `rsN_busy` drops in the cycle `rd_en` is high for that load.
- **Reset mid-operation:** `rst_n` low immediately clears everything asynchronously. A pending hold is lost, and upstream reissues.
- **Busy-while-write:** a register written by EX while busy stays busy until its load drains. The later load overwrites the EX value, which gives in-order commit.

## Configuration
- **`SVC_RV_WB_STARVE_EN` defined:** the starvation counter and the `ex_stall` logic are compiled in.
- **`SVC_RV_WB_STARVE_EN` undefined:**
  - `ex_stall` is tied to 0 and `STARVE_MAX` is unused.
  - A load hold waits indefinitely behind continuous EX writes.
  - Upstream guarantees bubbles in this build.

## Structure
- **`svc_rv_pkg`** holds `REG_ADDR_W`=5, `NUM_REGS`=32, and the `reg_addr_t` typedef.
- **Sub-module `svc_rv_scoreboard`:** set/clear ports, two query ports, x0 forced clear.
- **Top level** holds the hold register, the arbitration, the output register and the starvation counter.

## Test plan
- **Reset:** during and after reset, `rd_en`=0, `ld_ready`=1, `rs1_busy`=0 for all 32 addresses.
- **EX write:** EX to x5 with 0x12345678 → `rd_en`=1, `rd_addr`=5, `rd_data`=0x12345678 one cycle later. EX to x0 → `rd_en` stays 0.
- **Load path:**
  - `ld_issue` x7 → `rs1_busy`=1 with `rs1_addr`=7.
  - Load data 0xCAFEBABE to x7 → `rd_en`=1, `rd_addr`=7, `rd_data`=0xCAFEBABE two cycles after the handshake, with `rs1_busy`=0 in that cycle.
- **Conflict:**
  - Hold full (x3, 0x33333333) while EX writes x4 (0x44444444) → x4 is written first, x3 the next cycle.
  - `ld_ready`=0 until the drain cycle.
- **Starvation** (macro on, `STARVE_MAX`=4):
  - Continuous EX requests with the hold full → `ex_stall` rises after 4 blocked cycles.
  - Hold drains while `ex_stall` is high.
  - `ex_stall` falls the next cycle.
- **Simultaneous set/clear:** drain of x9 coincides with `ld_issue` x9 → x9 remains busy. Async reset asserted mid-hold → hold empty, scoreboard clear.

Source files
------------

// File: rtl/svc_rv_pkg.sv
// Shared register-file geometry for the svc RV core.
package svc_rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hard-wired zero: never written, never pending
  function automatic logic is_x0(reg_addr_t a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/svc_rv_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register.
// Set and clear on the same address in the same cycle leaves the bit set,
// since the newer load is still outstanding. x0 is never busy.
module svc_rv_scoreboard
  import svc_rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);

  localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // One-hot decode of the set and clear requests
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_addr] = 1'b1;
    if (clr_en) clr_vec[clr_addr] = 1'b1;
  end

  // Busy vector update: clear first, then set, so set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= ((busy & ~clr_vec) | set_vec) & X0_MASK;
  end

  // Queries see pre-update state; no bypass of this cycle's set/clear
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/svc_rv_wb.sv
// Writeback sequencer for the svc RV register file.
// Arbitrates EX results against a one-entry late-load hold, registers the
// winner onto the regfile write port, and owns the pending-load scoreboard.
// Optional macro SVC_RV_WB_STARVE_EN: when defined, a starvation counter
// raises ex_stall so a blocked load eventually drains; otherwise ex_stall=0.
module svc_rv_wb
  import svc_rv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  reg_addr_t       ex_rd_addr,
  input  logic [XLEN-1:0] ex_rd_data,
  output logic            ex_stall,
  input  logic            ld_issue,
  input  reg_addr_t       ld_issue_addr,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  reg_addr_t       ld_rd_addr,
  input  logic [XLEN-1:0] ld_data,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_en,
  output reg_addr_t       rd_addr,
  output logic [XLEN-1:0] rd_data
);

  logic            hold_full;
  reg_addr_t       hold_addr;
  logic [XLEN-1:0] hold_data;
  logic            ex_req;
  logic            drain;
  logic            ld_fire;

  // EX to x0 is a no-op; EX during a stall is a protocol violation and ignored
  assign ex_req   = ex_valid && !is_x0(ex_rd_addr) && !ex_stall;
  // Hold wins when forced by the stall, otherwise only when EX is idle
  assign drain    = hold_full && (ex_stall || !ex_req);
  // Drain and refill can overlap in one cycle
  assign ld_ready = !hold_full || drain;
  assign ld_fire  = ld_valid && ld_ready;

  // Load hold register; loads to x0 are accepted and dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (ld_fire && !is_x0(ld_rd_addr)) begin
      hold_full <= 1'b1;
      hold_addr <= ld_rd_addr;
      hold_data <= ld_data;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

  // Regfile write port; addr/data keep their value on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (ex_req) begin
      rd_en   <= 1'b1;
      rd_addr <= ex_rd_addr;
      rd_data <= ex_rd_data;
    end else if (drain) begin
      rd_en   <= 1'b1;
      rd_addr <= hold_addr;
      rd_data <= hold_data;
    end else begin
      rd_en   <= 1'b0;
    end
  end

  svc_rv_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (ld_issue && !is_x0(ld_issue_addr)),
    .set_addr (ld_issue_addr),
    .clr_en   (drain),
    .clr_addr (hold_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

`ifdef SVC_RV_WB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          stall_q;

  // Blocked-cycle count, saturating at the threshold
  always_comb begin
    starve_nxt = starve_cnt;
    if (drain)
      starve_nxt = '0;
    else if (hold_full && starve_cnt != CW'(STARVE_MAX))
      starve_nxt = starve_cnt + 1'b1;
  end

  // Stall raises once the count hits the threshold and drops after the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (drain)                              stall_q <= 1'b0;
      else if (starve_nxt == CW'(STARVE_MAX)) stall_q <= 1'b1;
    end
  end

  assign ex_stall = stall_q;
`else
  // Upstream guarantees bubbles in this build
  localparam int starve_max_unused = STARVE_MAX;
  assign ex_stall = 1'b0;
`endif

endmodule

// File: tb/tb_svc_rv_wb.sv
// Bench for svc_rv_wb: directed scenarios plus random traffic, all checked
// against a transaction-level model of the writeback rules.
module tb_svc_rv_wb;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid, ld_issue, ld_valid;
  logic [4:0]      ex_rd_addr, ld_issue_addr, ld_rd_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] ex_rd_data, ld_data;
  logic            ex_stall, ld_ready, rs1_busy, rs2_busy, rd_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;

  always #5 clk = ~clk;

  svc_rv_wb #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data),
    .ex_stall(ex_stall),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd_addr(ld_rd_addr),
    .ld_data(ld_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: hold as a queue, scoreboard as a bit array
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t        m_hold[$];
  bit         m_busy[32];
  bit         m_rd_en;
  logic [4:0] m_rd_addr;
  logic [31:0] m_rd_data;
  int         m_blocked;
  bit         m_stall;

  task automatic model_reset();
    m_hold.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_rd_en = 0; m_rd_addr = '0; m_rd_data = '0;
    m_blocked = 0; m_stall = 0;
  endtask

  task automatic idle();
    ex_valid = 0; ex_rd_addr = '0; ex_rd_data = '0;
    ld_issue = 0; ld_issue_addr = '0;
    ld_valid = 0; ld_rd_addr = '0; ld_data = '0;
  endtask

  // Called in the low clock phase with inputs already driven; checks, then
  // advances the model and the DUT by one clock and returns at the next negedge
  task automatic step();
    bit full, ex_ok, drain, ld_rdy;
    wr_t h;
    #1;
    full   = (m_hold.size() != 0);
    ex_ok  = ex_valid && (ex_rd_addr != 0) && !m_stall;
    drain  = full && (m_stall || !ex_ok);
    ld_rdy = !full || drain;
    chk("ld_ready", ld_ready, ld_rdy);
    chk("ex_stall", ex_stall, m_stall);
    chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
    chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
    chk("rd_en",    rd_en,    m_rd_en);
    chk("rd_addr",  rd_addr,  m_rd_addr);
    chk("rd_data",  rd_data,  m_rd_data);
    if (ex_ok) begin
      m_rd_en = 1; m_rd_addr = ex_rd_addr; m_rd_data = ex_rd_data;
    end else if (drain) begin
      h = m_hold[0];
      m_rd_en = 1; m_rd_addr = h.a; m_rd_data = h.d;
    end else begin
      m_rd_en = 0;
    end
    if (drain) m_busy[m_hold[0].a] = 0;
    if (ld_issue && ld_issue_addr != 0) m_busy[ld_issue_addr] = 1;
`ifdef SVC_RV_WB_STARVE_EN
    if (drain) begin
      m_blocked = 0; m_stall = 0;
    end else begin
      if (full) m_blocked++;
      if (m_blocked >= STARVE_MAX) m_stall = 1;
    end
`endif
    if (drain) void'(m_hold.pop_front());
    if (ld_valid && ld_rdy && ld_rd_addr != 0) begin
      h.a = ld_rd_addr; h.d = ld_data;
      m_hold.push_back(h);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    idle();
    rs1_addr = '0; rs2_addr = '0;
    model_reset();

    // Reset state, including every scoreboard entry
    #2;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #1 chk("rst_rs1_busy", rs1_busy, 1'b0);
    end
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_ex_stall", ex_stall, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rs1_addr = '0;
    step();

    // EX write to x5, then EX to x0 which must not write
    ex_valid = 1; ex_rd_addr = 5; ex_rd_data = 32'h12345678;
    step();
    idle();
    #1 chk("ex5_en", rd_en, 1'b1);
    chk("ex5_addr", rd_addr, 5'd5);
    chk("ex5_data", rd_data, 32'h12345678);
    step();
    ex_valid = 1; ex_rd_addr = 0; ex_rd_data = 32'hDEADBEEF;
    step();
    idle();
    #1 chk("ex0_en", rd_en, 1'b0);
    step();

    // Load path: issue x7, busy visible, data returns two cycles later
    ld_issue = 1; ld_issue_addr = 7;
    step();
    idle(); rs1_addr = 7;
    #1 chk("ld7_busy", rs1_busy, 1'b1);
    step();
    ld_valid = 1; ld_rd_addr = 7; ld_data = 32'hCAFEBABE;
    step();
    idle();
    step();
    #1 chk("ld7_en", rd_en, 1'b1);
    chk("ld7_addr", rd_addr, 5'd7);
    chk("ld7_data", rd_data, 32'hCAFEBABE);
    chk("ld7_busy_clr", rs1_busy, 1'b0);
    step();

    // Conflict: hold x3 while EX writes x4; EX first, hold next
    ld_issue = 1; ld_issue_addr = 3;
    step();
    idle(); ld_valid = 1; ld_rd_addr = 3; ld_data = 32'h33333333;
    step();
    idle(); ex_valid = 1; ex_rd_addr = 4; ex_rd_data = 32'h44444444;
    #1 chk("cf_ld_ready_blk", ld_ready, 1'b0);
    step();
    idle();
    #1 chk("cf_first_addr", rd_addr, 5'd4);
    chk("cf_first_data", rd_data, 32'h44444444);
    chk("cf_ld_ready_drain", ld_ready, 1'b1);
    step();
    #1 chk("cf_second_addr", rd_addr, 5'd3);
    chk("cf_second_data", rd_data, 32'h33333333);
    step();

    // Simultaneous set/clear on x9: set wins
    ld_issue = 1; ld_issue_addr = 9;
    step();
    idle(); ld_valid = 1; ld_rd_addr = 9; ld_data = 32'h99999999;
    step();
    idle(); ld_issue = 1; ld_issue_addr = 9;
    step();
    idle(); rs2_addr = 9;
    #1 chk("sc_x9_busy", rs2_busy, 1'b1);
    chk("sc_x9_written", rd_addr, 5'd9);
    ld_valid = 1; ld_rd_addr = 9; ld_data = 32'h09090909;
    step();
    idle();
    step();
    #1 chk("sc_x9_clear", rs2_busy, 1'b0);
    step();

`ifdef SVC_RV_WB_STARVE_EN
    // Starvation: hold x3 behind continuous EX until ex_stall forces a drain
    ld_issue = 1; ld_issue_addr = 3;
    step();
    idle(); ld_valid = 1; ld_rd_addr = 3; ld_data = 32'h5A5A5A5A;
    step();
    idle();
    for (k = 0; k < 20; k++) begin
      ex_valid = 1; ex_rd_addr = 4; ex_rd_data = $urandom;
      step();
      #1;
      if (ex_stall) break;
    end
    chk("starve_blocked_cycles", 32'(k + 1), 32'(STARVE_MAX));
    step();
    #1 chk("starve_stall_fall", ex_stall, 1'b0);
    chk("starve_drain_addr", rd_addr, 5'd3);
    chk("starve_drain_data", rd_data, 32'h5A5A5A5A);
    idle();
    step();
`endif

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      ex_valid      = ($urandom_range(0, 9) < 6);
      ex_rd_addr    = 5'($urandom_range(0, 7));
      ex_rd_data    = $urandom;
      ld_issue      = ($urandom_range(0, 9) < 3);
      ld_issue_addr = 5'($urandom_range(0, 7));
      ld_valid      = ($urandom_range(0, 9) < 4);
      ld_rd_addr    = 5'($urandom_range(0, 7));
      ld_data       = $urandom;
      rs1_addr      = 5'($urandom_range(0, 7));
      rs2_addr      = 5'($urandom_range(0, 7));
      step();
    end

    // Async reset with a load pending in the hold
    idle();
    ld_issue = 1; ld_issue_addr = 6;
    step();
    idle(); ld_valid = 1; ld_rd_addr = 6; ld_data = 32'h66666666;
    step();
    idle(); ex_valid = 1; ex_rd_addr = 2; ex_rd_data = 32'h22222222;
    rs1_addr = 6;
    #1 chk("mr_hold_full", ld_ready, 1'b0);
    chk("mr_busy_before", rs1_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("mr_ld_ready", ld_ready, 1'b1);
    chk("mr_busy", rs1_busy, 1'b0);
    chk("mr_rd_en", rd_en, 1'b0);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
